// File: rtl/uart_cmd_parser.sv
// Command front end for the MITM tap: decodes PC-side UART bytes into forwarding
// enable updates and answers every command with one ACK/NAK/status byte.
module uart_cmd_parser #(
  parameter int SYSTEM_CLOCK  = 32000000,
  parameter int BAUD_RATE     = 9600,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [1:0] en_mask,
  output logic       cmd_err
);

  localparam int TIMEOUT_CYCLES = (SYSTEM_CLOCK / BAUD_RATE) * 10 * TIMEOUT_CHARS;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_EN     = 8'h65;
  localparam logic [7:0] OP_DIS    = 8'h64;
  localparam logic [7:0] OP_STAT   = 8'h73;
  localparam logic [7:0] RPL_ACK   = 8'h6B;
  localparam logic [7:0] RPL_NAK   = 8'h6E;
  localparam logic [7:0] RPL_STAT  = 8'h30;

  typedef enum logic [1:0] {IDLE, ARG, SEND, WAIT_BUSY} state_t;

  state_t            state_q;
  logic              op_en_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tx_en_q;
  logic [7:0]        tx_data_q;
  logic [1:0]        en_mask_q;
  logic              cmd_err_q;
  logic [1:0]        arg_mask_d;

  // Mask that a well-formed argument byte would produce for the latched opcode.
  always_comb begin
    arg_mask_d = en_mask_q;
    if (op_en_q) arg_mask_d = en_mask_q | rx_data[1:0];
    else         arg_mask_d = en_mask_q & ~rx_data[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_en_q   <= 1'b0;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      en_mask_q <= 2'b00;
      cmd_err_q <= 1'b0;
    end else begin
      tx_en_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == OP_EN || rx_data == OP_DIS) begin
              op_en_q <= (rx_data == OP_EN);
              cnt_q   <= '0;
              state_q <= ARG;
            end else if (rx_data == OP_STAT) begin
              tx_data_q <= RPL_STAT | {6'b0, en_mask_q};
              state_q   <= SEND;
            end else begin
              tx_data_q <= RPL_NAK;
              cmd_err_q <= 1'b1;
              state_q   <= SEND;
            end
          end
        end
        ARG: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // An argument arriving in the expiry cycle takes priority over the timeout.
          if (rx_valid) begin
            if (rx_data[7:2] == 6'd0) begin
              en_mask_q <= arg_mask_d;
              tx_data_q <= RPL_ACK;
            end else begin
              tx_data_q <= RPL_NAK;
              cmd_err_q <= 1'b1;
            end
            state_q <= SEND;
          end else if (cnt_q == CNT_LAST) begin
            tx_data_q <= RPL_NAK;
            cmd_err_q <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (tx_rdy) begin
            tx_en_q <= 1'b1;
            state_q <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // uart_tx must drop rdy before the next reply may be loaded.
          if (!tx_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (rx_valid && (state_q == SEND || state_q == WAIT_BUSY)) cmd_err_q <= 1'b1;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign en_mask = en_mask_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser with a byte-level command model and a
// simple uart_tx responder that goes busy for a few cycles after each load.
module tb_uart_cmd_parser;
  localparam int SC = 1000000;
  localparam int BR = 100000;
  localparam int TC = 4;
  localparam int T_CYC = (SC / BR) * 10 * TC;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [1:0] en_mask;
  logic       cmd_err;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .SYSTEM_CLOCK(SC),
    .BAUD_RATE(BR),
    .TIMEOUT_CHARS(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_rdy(tx_rdy),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .en_mask(en_mask),
    .cmd_err(cmd_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  int last_err_cyc = -1;
  int last_tx_cyc = -1;
  int busy = 0;
  bit hold_low = 1'b0;
  logic [7:0] replies[$];
  logic [7:0] last_reply = 8'h00;

  // Reference: current mask and pending opcode (0 none, 1 enable, 2 disable).
  logic [1:0] m_mask = 2'b00;
  int m_pending = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs at the falling edge, run the uart_tx responder, clear rx strobe.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_en) begin
      replies.push_back(tx_data);
      last_tx_cyc = cyc;
      busy = 3;
    end
    if (cmd_err) begin
      err_pulses++;
      last_err_cyc = cyc;
    end
    tx_rdy = !hold_low && (busy == 0);
    if (busy > 0) busy--;
    rx_valid = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit has_r, output logic [7:0] r,
                            output int e);
    has_r = 1'b1;
    e = 0;
    r = 8'h6E;
    if (m_pending == 0) begin
      if (b == 8'h65) begin m_pending = 1; has_r = 1'b0; end
      else if (b == 8'h64) begin m_pending = 2; has_r = 1'b0; end
      else if (b == 8'h73) r = 8'h30 + {6'd0, m_mask};
      else e = 1;
    end else begin
      if (b < 8'd4) begin
        for (int i = 0; i < 2; i++)
          if (b[i]) m_mask[i] = (m_pending == 1);
        r = 8'h6B;
      end else begin
        e = 1;
      end
      m_pending = 0;
    end
  endtask

  task automatic wait_reply(input int limit, output bit got, output logic [7:0] r);
    for (int i = 0; i < limit && replies.size() == 0; i++) tick();
    got = (replies.size() != 0);
    r = 8'h00;
    if (!got) check("reply_timeout", 0, 1);
    else begin
      r = replies.pop_front();
      last_reply = r;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    bit has_r, got;
    logic [7:0] r_exp, r_got;
    int e_exp, e0, s;
    model_byte(b, has_r, r_exp, e_exp);
    e0 = err_pulses;
    r_got = 8'h00;
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    s = cyc;
    check("mask_after_strobe", {30'd0, en_mask}, {30'd0, m_mask});
    if (has_r) begin
      wait_reply(50, got, r_got);
      if (got) begin
        check("reply", {24'd0, r_got}, {24'd0, r_exp});
        check("latency", last_tx_cyc - (s - 1), 2);
      end
      repeat (6) tick();
      check("single_reply", replies.size(), 0);
      check("tx_data_held", {24'd0, tx_data}, {24'd0, r_exp});
    end else begin
      tick();
      check("no_reply_on_opcode", replies.size(), 0);
    end
    check("err_pulses", err_pulses - e0, e_exp);
    $display("xfer byte=%02h reply=%02h mask=%b", b, has_r ? r_got : 8'h00, en_mask);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_mask = 2'b00;
    m_pending = 0;
  endtask

  initial begin
    logic [7:0] op, arg, r;
    int k, e0, s0;
    bit has_r, got;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_rdy = 1'b1;
    repeat (3) tick();
    check("rst_en_mask", {30'd0, en_mask}, 0);
    check("rst_tx_en", {31'd0, tx_en}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_cmd_err", {31'd0, cmd_err}, 0);
    rst = 1'b0;
    tick();

    // Directed command sequence.
    xfer(8'h65); xfer(8'h03);
    check("tp_en_mask_11", {30'd0, en_mask}, 32'h3);
    check("tp_ack", {24'd0, last_reply}, 32'h6B);
    xfer(8'h64); xfer(8'h01);
    check("tp_en_mask_10", {30'd0, en_mask}, 32'h2);
    xfer(8'h73);
    check("tp_status", {24'd0, last_reply}, 32'h32);
    xfer(8'h65); xfer(8'h04);
    check("tp_bad_arg_nak", {24'd0, last_reply}, 32'h6E);
    xfer(8'h41);
    check("tp_unknown_nak", {24'd0, last_reply}, 32'h6E);
    xfer(8'h00); xfer(8'h65); xfer(8'h00);
    check("tp_zero_arg_ack", {24'd0, last_reply}, 32'h6B);

    // Argument timeout: nothing in the last allowed cycle, NAK in the expiry cycle.
    model_byte(8'h65, has_r, r, k);
    e0 = err_pulses;
    rx_valid = 1'b1; rx_data = 8'h65;
    tick();
    s0 = cyc;
    repeat (T_CYC - 1) tick();
    check("no_early_timeout", err_pulses - e0, 0);
    tick();
    check("timeout_err", err_pulses - e0, 1);
    check("timeout_err_cycle", last_err_cyc - s0, T_CYC);
    m_pending = 0;
    wait_reply(20, got, r);
    check("timeout_nak", {24'd0, r}, 32'h6E);
    repeat (6) tick();
    $display("timeout reply=%02h mask=%b", r, en_mask);

    // Argument arriving in exactly the expiry cycle is accepted.
    model_byte(8'h65, has_r, r, k);
    rx_valid = 1'b1; rx_data = 8'h65;
    tick();
    repeat (T_CYC - 1) tick();
    xfer(8'h01);
    check("expiry_arg_ack", {24'd0, last_reply}, 32'h6B);

    // uart_tx held busy: no load until rdy, drops in SEND and WAIT_BUSY.
    hold_low = 1'b1;
    tick();
    e0 = err_pulses;
    rx_valid = 1'b1; rx_data = 8'h73;
    tick();
    repeat (1000) tick();
    check("hold_no_tx", replies.size(), 0);
    check("hold_tx_data", {24'd0, tx_data}, 32'h30 + {30'd0, m_mask});
    rx_valid = 1'b1; rx_data = 8'h65;
    tick();
    check("drop_in_send_err", err_pulses - e0, 1);
    hold_low = 1'b0;
    wait_reply(20, got, r);
    check("hold_reply", {24'd0, r}, 32'h30 + {30'd0, m_mask});
    rx_valid = 1'b1; rx_data = 8'h65;
    tick();
    check("drop_in_wait_err", err_pulses - e0, 2);
    repeat (6) tick();
    check("hold_single_reply", replies.size(), 0);
    check("drop_mask_kept", {30'd0, en_mask}, {30'd0, m_mask});
    $display("hold reply=%02h mask=%b", r, en_mask);
    xfer(8'h73);

    // Randomized command stream.
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      op = 8'($urandom_range(0, 255));
      arg = 8'($urandom_range(0, 3));
      if (k <= 4) op = ($urandom_range(0, 1) != 0) ? 8'h65 : 8'h64;
      if (k == 4) arg = 8'($urandom_range(4, 255));
      if (k == 5) op = 8'h73;
      xfer(op);
      if (m_pending != 0) begin
        repeat ($urandom_range(0, 20)) tick();
        xfer(arg);
      end
    end

    // Reset while waiting for an argument.
    xfer(8'h65); xfer(8'h03);
    xfer(8'h65);
    repeat (3) tick();
    reset_dut();
    check("rst_arg_mask", {30'd0, en_mask}, 0);
    repeat (20) tick();
    check("rst_arg_no_reply", replies.size(), 0);
    xfer(8'h03);
    check("rst_arg_then_nak", {24'd0, last_reply}, 32'h6E);

    // Reset while a reply is waiting for uart_tx: it is never sent.
    hold_low = 1'b1;
    tick();
    rx_valid = 1'b1; rx_data = 8'h73;
    tick();
    repeat (5) tick();
    reset_dut();
    hold_low = 1'b0;
    repeat (20) tick();
    check("rst_send_no_reply", replies.size(), 0);
    xfer(8'h73);
    check("rst_send_status", {24'd0, last_reply}, 32'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command front end for the MITM tap. Consumes bytes from the PC-side uart_rx (valid/data_rx) and decodes single-byte and two-byte commands.
- Drives the 2-bit forwarding-enable mask for bus 1 and bus 2.
- Returns a one-byte ACK, NAK or status reply through the PC-side uart_tx (en/data_in/rdy handshake).

Parameters:
- SYSTEM_CLOCK, 32000000, clock frequency in Hz.
- BAUD_RATE, 9600, UART bit rate.
- TIMEOUT_CHARS, 4, character times allowed between opcode and argument byte. TIMEOUT_CYCLES = (SYSTEM_CLOCK/BAUD_RATE)*10*TIMEOUT_CHARS = 133320 at defaults, integer division.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe from uart_rx, byte available
- rx_data  in  8  received byte, qualified by rx_valid
- tx_rdy  in  1  uart_tx idle and able to accept a byte
- tx_en  out  1  one-cycle load strobe to uart_tx
- tx_data  out  8  byte to uart_tx, held stable from tx_en until the next load
- en_mask  out  2  bit0 enables bus 1 forwarding, bit1 enables bus 2 forwarding
- cmd_err  out  1  one-cycle pulse on NAK, timeout or overrun

Behaviour:
- Reset: state IDLE, en_mask=2'b00, tx_en=0, tx_data=8'h00, cmd_err=0, timeout counter=0.
- Reset mid-operation aborts any pending command or reply. A reply not yet strobed is never sent.
- States: IDLE, ARG, SEND, WAIT_BUSY.
- IDLE, rx_valid with rx_data:
  - 8'h65 'e' or 8'h64 'd': latch opcode, clear counter, go to ARG.
  - 8'h73 's': tx_data <= 8'h30|{6'b0,en_mask}, go to SEND.
  - Any other byte: tx_data <= 8'h6E 'n', pulse cmd_err, go to SEND.
- ARG: counter increments each cycle.
  - rx_valid with rx_data[7:2]==0:
    - 'e' sets en_mask <= en_mask | rx_data[1:0].
    - 'd' sets en_mask <= en_mask & ~rx_data[1:0].
    - Both load tx_data <= 8'h6B 'k' and go to SEND. The new en_mask is visible the cycle after the rx_valid cycle.
  - rx_valid with rx_data[7:2]!=0: en_mask unchanged, tx_data <= 'n', pulse cmd_err, go to SEND.
  - Counter reaches TIMEOUT_CYCLES-1 with no rx_valid: pulse cmd_err, tx_data <= 'n', go to SEND.
  - If rx_valid arrives in the same cycle the counter expires, the byte wins and is processed as an argument.
- SEND: tx_en=1 for exactly the one cycle in which tx_rdy==1, then go to WAIT_BUSY. If tx_rdy==0, stay in SEND with tx_en=0.
- WAIT_BUSY: stay until tx_rdy==0, then go to IDLE. This guarantees a single load per reply.
- rx_valid in SEND or WAIT_BUSY: byte dropped, cmd_err pulses, en_mask and state unchanged.
- Each command produces exactly one reply byte.
- en_mask changes only on a valid 'e' or 'd' argument. 'e'/'d' with argument 8'h00 is legal: ACK with no mask change.
- All outputs are registered. Minimum latency from argument rx_valid to tx_en is 2 cycles when tx_rdy is held high.

Test Plan:
- After reset: rx 8'h65, then 8'h03 -> en_mask=2'b11 one cycle after the argument strobe; exactly one tx_en with tx_data=8'h6B.
- From en_mask=2'b11: rx 8'h64, then 8'h01 -> en_mask=2'b10, reply 8'h6B. Then rx 8'h73 -> reply 8'h32.
- rx 8'h65, then 8'h04 -> en_mask unchanged, cmd_err pulse, reply 8'h6E. Separately, rx 8'h41 -> immediate 8'h6E, parser returns to IDLE.
- rx 8'h65 and no further byte for 133320 cycles -> cmd_err, reply 8'h6E. Repeat with the argument arriving in exactly the expiry cycle -> argument accepted, reply 8'h6B.
- Hold tx_rdy=0 for 1000 cycles after a command -> tx_en stays 0. Raise tx_rdy -> single tx_en pulse. A byte injected while in WAIT_BUSY -> dropped with a cmd_err pulse.
- Assert rst while in ARG after 8'h65 -> en_mask=2'b00, no reply sent. A following 8'h03 is treated as an unknown opcode (reply 8'h6E).
